regfile_reader: RTL and testbench



---
 rtl/tinygpu_pkg.sv | 35 +++
 rtl/regfile_reader.sv | 132 +++++++++++++
 tb/tb_regfile_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinygpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tinygpu_pkg
//  Description : Shared constants and types for the register-file reader.
//                Register-file geometry, sweep-count width, the reader
//                FSM state encoding and a helper that clamps a sweep length.
//  Revision    : 1.0 - initial release
// ============================================================================
package tinygpu_pkg;

    // Register-file geometry
    localparam int DATA_W = 16;
    localparam int RN_W   = 4;
    localparam int NREGS  = 1 << RN_W;

    // Sweep length needs one bit more than a register number (0..NREGS)
    localparam int CNT_W  = RN_W + 1;

    // Reader FSM state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } rdr_state_t;

    // A sweep never covers more than the whole file, so longer requests
    // are trimmed to NREGS and each register is still read exactly once.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] c_max;
        c_max = CNT_W'(NREGS);
        return (n > c_max) ? c_max : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_reader.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_reader
//  Description : Read-side sequencer for the 16 x 16-bit register file.
//                On a start pulse it sweeps a contiguous, wrapping range of
//                register numbers through one read port and emits each
//                sampled word on a valid/ready stream, tagged with its
//                register number.
//
//  Ports
//    clock      in   system clock, rising edge
//    resetn     in   asynchronous active-low reset
//    start      in   single-cycle request, honoured only when idle
//    first_reg  in   first register number of the sweep
//    num_regs   in   number of registers to read (0..NREGS)
//    rn         out  register number presented to the file's read port
//    q          in   combinational read data of the file for rn
//    out_data   out  sampled register value
//    out_reg    out  register number that out_data came from
//    out_valid  out  out_data / out_reg / out_last are valid
//    out_ready  in   consumer accepts the current word
//    out_last   out  final word of the sweep
//    busy       out  sweep in progress
//    done       out  one-cycle pulse when a sweep completes
//
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_reader
    import tinygpu_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [RN_W-1:0]   first_reg,
    input  logic [CNT_W-1:0]  num_regs,
    output logic [RN_W-1:0]   rn,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] out_data,
    output logic [RN_W-1:0]   out_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    rdr_state_t         r_state;
    logic [CNT_W-1:0]   r_count;      // words still to be delivered, incl. current
    logic [RN_W-1:0]    r_rn;
    logic [DATA_W-1:0]  r_out_data;
    logic [RN_W-1:0]    r_out_reg;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rn        <= '0;
            r_out_data  <= '0;
            r_out_reg   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is a single-cycle pulse
            r_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (num_regs == '0) begin
                            // Empty sweep: report completion, never stream
                            r_done <= 1'b1;
                        end else begin
                            r_rn    <= first_reg;
                            r_count <= clamp_count(num_regs);
                            r_busy  <= 1'b1;
                            r_state <= SAMPLE;
                        end
                    end
                end

                SAMPLE: begin
                    // rn has been stable for this whole cycle, so the
                    // combinational q is settled at the capture edge.
                    r_out_data  <= q;
                    r_out_reg   <= r_rn;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_count == CNT_W'(1));
                    r_state     <= HOLD;
                end

                HOLD: begin
                    // Without a handshake everything holds, keeping the
                    // word and rn stable for the consumer.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_out_last <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            // RN_W-bit add wraps the highest register to 0
                            r_rn    <= r_rn + RN_W'(1);
                            r_count <= r_count - CNT_W'(1);
                            r_state <= SAMPLE;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rn        = r_rn;
    assign out_data  = r_out_data;
    assign out_reg   = r_out_reg;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_reader
//  Description : Self-checking directed bench for regfile_reader. Models the
//                register file as a combinational array driven by rn and
//                checks sweep contents, ordering, stalls, reset abort and
//                start-while-busy behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_reader;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [3:0]  first_reg;
    logic [4:0]  num_regs;
    logic [3:0]  rn;
    logic [15:0] q;
    logic [15:0] out_data;
    logic [3:0]  out_reg;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] regs [16];

    int tests_run;
    int tests_failed;

    // Words collected by the sweep driver
    logic [3:0]  got_reg  [32];
    logic [15:0] got_data [32];
    logic        got_last [32];

    regfile_reader u_dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .first_reg (first_reg),
        .num_regs  (num_regs),
        .rn        (rn),
        .q         (q),
        .out_data  (out_data),
        .out_reg   (out_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    assign q = regs[rn];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Runs one sweep. cyc 0 is the cycle right after the start edge.
    // Stalls each word for 'stall' cycles; pulses a second start with
    // first_reg=10/num_regs=2 at cyc == restart_cyc (if >= 0).
    task automatic do_sweep(input logic [3:0] f, input logic [4:0] n,
                            input int stall, input int restart_cyc,
                            output int nw, output int done_cyc,
                            output int stable_err, output int overlap,
                            output int saw_valid, output int saw_busy,
                            output int done_after);
        int cyc;
        int stall_cnt;
        bit finished;
        logic [15:0] hold_data;
        logic [3:0]  hold_rn;
        logic [3:0]  hold_reg;
        nw = 0; done_cyc = -1; stable_err = 0; overlap = 0;
        saw_valid = 0; saw_busy = 0; done_after = 0;
        hold_data = '0; hold_rn = '0; hold_reg = '0;
        @(posedge clock); #1;
        start = 1'b1; first_reg = f; num_regs = n; out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0; stall_cnt = 0; finished = 1'b0;
        while (!finished && cyc < 400) begin
            if (cyc == restart_cyc) begin
                start = 1'b1; first_reg = 4'd10; num_regs = 5'd2;
            end else begin
                start = 1'b0;
            end
            if (busy && done) overlap++;
            if (busy) saw_busy = 1;
            if (out_valid) saw_valid = 1;
            if (done) begin
                done_cyc = cyc;
                finished = 1'b1;
            end else begin
                if (out_valid) begin
                    if (stall_cnt == 0) begin
                        hold_data = out_data; hold_rn = rn; hold_reg = out_reg;
                    end else if (out_data !== hold_data || rn !== hold_rn ||
                                 out_reg !== hold_reg) begin
                        stable_err++;
                    end
                    if (stall_cnt < stall) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                        if (nw < 32) begin
                            got_reg[nw] = out_reg; got_data[nw] = out_data;
                            got_last[nw] = out_last;
                        end
                        nw++;
                        stall_cnt = 0;
                    end
                end else begin
                    out_ready = 1'b1;
                end
                @(posedge clock); #1;
                cyc++;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        logic [45:0] all_out;
        all_out = {rn, out_data, out_reg, out_valid, out_last, busy, done};
        if (all_out !== 46'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %0h expected 0", all_out);
        end
        tests_run++;
    endtask

    task automatic test_full_sweep();
        int nw, dc, se, ov, sv, sb, da;
        do_sweep(4'd0, 5'd16, 0, -1, nw, dc, se, ov, sv, sb, da);
        if (nw !== 16) begin
            tests_failed++; $display("FAIL full_count: got %0d expected 16", nw);
        end
        tests_run++;
        for (int i = 0; i < 16 && i < nw; i++) begin
            if (got_reg[i] !== 4'(i)) begin
                tests_failed++;
                $display("FAIL full_reg[%0d]: got %0d expected %0d", i, got_reg[i], i);
            end
            tests_run++;
            if (got_data[i] !== 16'h1001 + 16'(i)) begin
                tests_failed++;
                $display("FAIL full_data[%0d]: got %h expected %h", i, got_data[i],
                         16'h1001 + 16'(i));
            end
            tests_run++;
            if (got_last[i] !== (i == 15)) begin
                tests_failed++;
                $display("FAIL full_last[%0d]: got %0d expected %0d", i, got_last[i], i == 15);
            end
            tests_run++;
        end
        if (dc !== 32) begin
            tests_failed++; $display("FAIL full_done_cycle: got %0d expected 32", dc);
        end
        tests_run++;
        if (ov !== 0) begin
            tests_failed++; $display("FAIL full_busy_done_overlap: got %0d expected 0", ov);
        end
        tests_run++;
        if (da !== 0) begin
            tests_failed++; $display("FAIL full_done_pulse_width: got %0d expected 0", da);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL full_busy_after: got %0d expected 0", busy);
        end
        tests_run++;
    endtask

    task automatic test_wrap();
        int nw, dc, se, ov, sv, sb, da;
        logic [3:0] e;
        do_sweep(4'd14, 5'd4, 0, -1, nw, dc, se, ov, sv, sb, da);
        if (nw !== 4) begin
            tests_failed++; $display("FAIL wrap_count: got %0d expected 4", nw);
        end
        tests_run++;
        for (int i = 0; i < 4 && i < nw; i++) begin
            e = 4'(14 + i);
            if (got_reg[i] !== e) begin
                tests_failed++;
                $display("FAIL wrap_reg[%0d]: got %0d expected %0d", i, got_reg[i], e);
            end
            tests_run++;
            if (got_data[i] !== 16'h1001 + 16'(e)) begin
                tests_failed++;
                $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_data[i],
                         16'h1001 + 16'(e));
            end
            tests_run++;
            if (got_last[i] !== (i == 3)) begin
                tests_failed++;
                $display("FAIL wrap_last[%0d]: got %0d expected %0d", i, got_last[i], i == 3);
            end
            tests_run++;
        end
        if (dc !== 8) begin
            tests_failed++; $display("FAIL wrap_done_cycle: got %0d expected 8", dc);
        end
        tests_run++;
    endtask

    task automatic test_zero();
        int nw, dc, se, ov, sv, sb, da;
        do_sweep(4'd5, 5'd0, 0, -1, nw, dc, se, ov, sv, sb, da);
        if (dc !== 0) begin
            tests_failed++; $display("FAIL zero_done_cycle: got %0d expected 0", dc);
        end
        tests_run++;
        for (int k = 0; k < 3; k++) begin
            if (out_valid) sv = 1;
            if (busy) sb = 1;
            @(posedge clock); #1;
        end
        if (sv !== 0) begin
            tests_failed++; $display("FAIL zero_valid_seen: got %0d expected 0", sv);
        end
        tests_run++;
        if (sb !== 0) begin
            tests_failed++; $display("FAIL zero_busy_seen: got %0d expected 0", sb);
        end
        tests_run++;
        if (da !== 0) begin
            tests_failed++; $display("FAIL zero_done_pulse_width: got %0d expected 0", da);
        end
        tests_run++;
    endtask

    task automatic test_stall();
        int nw, dc, se, ov, sv, sb, da;
        do_sweep(4'd3, 5'd3, 5, -1, nw, dc, se, ov, sv, sb, da);
        if (nw !== 3) begin
            tests_failed++; $display("FAIL stall_count: got %0d expected 3", nw);
        end
        tests_run++;
        if (se !== 0) begin
            tests_failed++; $display("FAIL stall_stability: got %0d changes expected 0", se);
        end
        tests_run++;
        for (int i = 0; i < 3 && i < nw; i++) begin
            if (got_reg[i] !== 4'(3 + i) || got_data[i] !== 16'h1004 + 16'(i)) begin
                tests_failed++;
                $display("FAIL stall_word[%0d]: got reg %0d data %h expected reg %0d data %h",
                         i, got_reg[i], got_data[i], 3 + i, 16'h1004 + 16'(i));
            end
            tests_run++;
        end
        if (dc !== 21) begin
            tests_failed++; $display("FAIL stall_done_cycle: got %0d expected 21", dc);
        end
        tests_run++;
    endtask

    task automatic test_reset_abort();
        int seen, k, nw, dc, se, ov, sv, sb, da, done_seen;
        logic [45:0] all_out;
        @(posedge clock); #1;
        start = 1'b1; first_reg = 4'd5; num_regs = 5'd5; out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        seen = 0; k = 0;
        // Stop at the second word while it is presented
        while (k < 20 && !(out_valid && seen == 1)) begin
            if (out_valid) seen++;
            @(posedge clock); #1;
            k++;
        end
        if (k >= 20) begin
            tests_failed++; $display("FAIL abort_second_word_timeout: got %0d cycles expected <20", k);
        end
        tests_run++;
        out_ready = 1'b0;
        resetn = 1'b0;
        #1;
        all_out = {rn, out_data, out_reg, out_valid, out_last, busy, done};
        if (all_out !== 46'd0) begin
            tests_failed++; $display("FAIL abort_outputs: got %0h expected 0", all_out);
        end
        tests_run++;
        @(posedge clock); @(posedge clock); #2;
        resetn = 1'b1;
        out_ready = 1'b1;
        done_seen = 0;
        for (int j = 0; j < 4; j++) begin
            if (done || out_valid) done_seen = 1;
            @(posedge clock); #1;
        end
        if (done_seen !== 0) begin
            tests_failed++; $display("FAIL abort_no_done: got %0d expected 0", done_seen);
        end
        tests_run++;
        do_sweep(4'd9, 5'd2, 0, -1, nw, dc, se, ov, sv, sb, da);
        if (nw !== 2 || got_reg[0] !== 4'd9 || got_data[0] !== 16'h100A ||
            got_reg[1] !== 4'd10 || got_data[1] !== 16'h100B || got_last[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_resweep: got n=%0d %0d:%h %0d:%h expected n=2 9:100a 10:100b",
                     nw, got_reg[0], got_data[0], got_reg[1], got_data[1]);
        end
        tests_run++;
    endtask

    task automatic test_start_while_busy();
        int nw, dc, se, ov, sv, sb, da;
        do_sweep(4'd0, 5'd4, 0, 2, nw, dc, se, ov, sv, sb, da);
        if (nw !== 4) begin
            tests_failed++; $display("FAIL busy_start_count: got %0d expected 4", nw);
        end
        tests_run++;
        for (int i = 0; i < 4 && i < nw; i++) begin
            if (got_reg[i] !== 4'(i) || got_data[i] !== 16'h1001 + 16'(i)) begin
                tests_failed++;
                $display("FAIL busy_start_word[%0d]: got reg %0d data %h expected reg %0d data %h",
                         i, got_reg[i], got_data[i], i, 16'h1001 + 16'(i));
            end
            tests_run++;
        end
        if (dc !== 8) begin
            tests_failed++; $display("FAIL busy_start_done_cycle: got %0d expected 8", dc);
        end
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start_idle_after: got busy %0d valid %0d expected 0 0", busy, out_valid);
        end
        tests_run++;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h1001 + 16'(i);
        resetn = 1'b0;
        start = 1'b0;
        first_reg = '0;
        num_regs = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        resetn = 1'b1;
        test_full_sweep();
        test_wrap();
        test_zero();
        test_stall();
        test_reset_abort();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
